// File: rtl/da_wave_gen.sv
// rtl/da_wave_gen.sv - DDS waveform generator feeding a DAC through a raw/scale/offset pipeline.
// Configuration is double-buffered: a shadow set is taken on handshake and applied at a period boundary.
module da_wave_gen #(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 12
) (
    input  logic               da_clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_freq_word,
    input  logic [1:0]         cfg_wave_sel,
    input  logic [DATA_W-1:0]  cfg_amp,
    input  logic [DATA_W-1:0]  cfg_offset,
    output logic [DATA_W-1:0]  da_data,
    output logic               sync_pulse,
    output logic [15:0]        cycle_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    localparam logic [1:0]        WAVE_SQUARE = 2'd0;
    localparam logic [1:0]        WAVE_SAW    = 2'd1;
    localparam logic [1:0]        WAVE_TRI    = 2'd2;
    localparam logic [DATA_W-1:0] DC_LEVEL    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] FULL_SCALE  = {DATA_W{1'b1}};

    state_t              state_q;
    logic                ready_q;

    logic [PHASE_W-1:0]  sh_freq_q;
    logic [1:0]          sh_wave_q;
    logic [DATA_W-1:0]   sh_amp_q;
    logic [DATA_W-1:0]   sh_off_q;

    logic [PHASE_W-1:0]  act_freq_q;
    logic [1:0]          act_wave_q;
    logic [DATA_W-1:0]   act_amp_q;
    logic [DATA_W-1:0]   act_off_q;

    logic [PHASE_W-1:0]  phase_q;
    logic                wrap_q;
    logic [15:0]         cnt_q;

    logic [DATA_W-1:0]   raw_q;
    logic [DATA_W-1:0]   amp_p1_q;
    logic [DATA_W-1:0]   off_p1_q;
    logic                sync_p1_q;
    logic [DATA_W-1:0]   scaled_q;
    logic [DATA_W-1:0]   off_p2_q;
    logic                sync_p2_q;
    logic [DATA_W-1:0]   data_q;
    logic                sync_q;

    logic                xfer;
    logic                running;
    logic                carry;
    logic [PHASE_W-1:0]  phase_sum;
    logic                wrap;
    logic                apply;
    logic [PHASE_W-1:0]  phase_d;
    logic [DATA_W-1:0]   raw_d;
    logic [2*DATA_W-1:0] prod_d;
    logic [DATA_W-1:0]   scaled_d;
    logic [DATA_W:0]     sum_d;
    logic [DATA_W-1:0]   data_d;

    assign xfer    = cfg_valid & ready_q;
    assign running = (state_q != ST_IDLE);
    assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, act_freq_q};
    assign wrap    = running & enable & carry;

    // Idle continuously mirrors shadow into active; leaving to idle flushes any pending set.
    assign apply   = (state_q == ST_IDLE) | ~enable
                   | ((state_q == ST_PENDING) & (carry | (act_freq_q == '0)));

    assign phase_d = (running & enable) ? phase_sum : '0;

    always_comb begin
        raw_d = '0;
        case (act_wave_q)
            WAVE_SQUARE: raw_d = phase_q[PHASE_W-1] ? '0 : FULL_SCALE;
            WAVE_SAW:    raw_d = phase_q[PHASE_W-1 -: DATA_W];
            WAVE_TRI:    raw_d = phase_q[PHASE_W-1] ? ~phase_q[PHASE_W-2 -: DATA_W]
                                                    :  phase_q[PHASE_W-2 -: DATA_W];
            default:     raw_d = DC_LEVEL;
        endcase
        if (state_q == ST_IDLE) begin
            raw_d = '0;
        end
    end

    assign prod_d   = {{DATA_W{1'b0}}, raw_q} * {{DATA_W{1'b0}}, amp_p1_q};
    assign scaled_d = prod_d[2*DATA_W-1:DATA_W];
    assign sum_d    = {1'b0, scaled_q} + {1'b0, off_p2_q};
    assign data_d   = sum_d[DATA_W] ? FULL_SCALE : sum_d[DATA_W-1:0];

    always_ff @(posedge da_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            sh_freq_q  <= '0;
            sh_wave_q  <= WAVE_SQUARE;
            sh_amp_q   <= FULL_SCALE;
            sh_off_q   <= '0;
            act_freq_q <= '0;
            act_wave_q <= WAVE_SQUARE;
            act_amp_q  <= FULL_SCALE;
            act_off_q  <= '0;
            phase_q    <= '0;
            wrap_q     <= 1'b0;
            cnt_q      <= '0;
            raw_q      <= '0;
            amp_p1_q   <= '0;
            off_p1_q   <= '0;
            sync_p1_q  <= 1'b0;
            scaled_q   <= '0;
            off_p2_q   <= '0;
            sync_p2_q  <= 1'b0;
            data_q     <= '0;
            sync_q     <= 1'b0;
        end else begin
            if (!enable) begin
                state_q <= ST_IDLE;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    // A handshake on the start edge still has to wait for a period boundary.
                    ST_IDLE: begin
                        state_q <= xfer ? ST_PENDING : ST_RUN;
                        ready_q <= ~xfer;
                    end
                    ST_RUN: begin
                        if (xfer) begin
                            state_q <= ST_PENDING;
                            ready_q <= 1'b0;
                        end
                    end
                    ST_PENDING: begin
                        if (apply) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                endcase
            end

            if (xfer) begin
                sh_freq_q <= cfg_freq_word;
                sh_wave_q <= cfg_wave_sel;
                sh_amp_q  <= cfg_amp;
                sh_off_q  <= cfg_offset;
            end
            if (apply) begin
                act_freq_q <= sh_freq_q;
                act_wave_q <= sh_wave_q;
                act_amp_q  <= sh_amp_q;
                act_off_q  <= sh_off_q;
            end

            phase_q <= phase_d;
            wrap_q  <= wrap;
            if (wrap) begin
                cnt_q <= cnt_q + 16'd1;
            end

            // Amplitude, offset and the period marker ride along with their sample.
            raw_q     <= raw_d;
            amp_p1_q  <= act_amp_q;
            off_p1_q  <= act_off_q;
            sync_p1_q <= wrap_q;
            scaled_q  <= scaled_d;
            off_p2_q  <= off_p1_q;
            sync_p2_q <= sync_p1_q;
            data_q    <= data_d;
            sync_q    <= sync_p2_q;
        end
    end

    assign cfg_ready  = ready_q;
    assign da_data    = data_q;
    assign sync_pulse = sync_q;
    assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_da_wave_gen.sv
// tb/tb_da_wave_gen.sv - directed-vector bench for da_wave_gen.
module tb_da_wave_gen;

    logic        da_clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_freq_word;
    logic [1:0]  cfg_wave_sel;
    logic [11:0] cfg_amp;
    logic [11:0] cfg_offset;
    logic [11:0] da_data;
    logic        sync_pulse;
    logic [15:0] cycle_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 da_clk = ~da_clk;

    da_wave_gen #(.PHASE_W(32), .DATA_W(12)) dut (
        .da_clk        (da_clk),
        .rst           (rst),
        .enable        (enable),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_freq_word (cfg_freq_word),
        .cfg_wave_sel  (cfg_wave_sel),
        .cfg_amp       (cfg_amp),
        .cfg_offset    (cfg_offset),
        .da_data       (da_data),
        .sync_pulse    (sync_pulse),
        .cycle_cnt     (cycle_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge da_clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] f, input logic [1:0] w,
                           input logic [11:0] a, input logic [11:0] o);
        cfg_freq_word = f;
        cfg_wave_sel  = w;
        cfg_amp       = a;
        cfg_offset    = o;
    endtask

    // Reset, configure while idle, then enable; returns just after the first RUN edge (E0).
    task automatic start_run(input logic [31:0] f, input logic [1:0] w,
                             input logic [11:0] a, input logic [11:0] o);
        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        tick;
        rst = 1'b0;
        set_cfg(f, w, a, o);
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
        tick;
        enable = 1'b1;
        tick;
    endtask

    initial begin
        logic [11:0] saw4 [4];
        int i;
        saw4[0] = 12'd0; saw4[1] = 12'd1023; saw4[2] = 12'd2047; saw4[3] = 12'd3071;

        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        set_cfg(32'h0, 2'd0, 12'd0, 12'd0);
        tick;
        tick;
        check_eq("rst_da", da_data, 0);
        check_eq("rst_sync", sync_pulse, 0);
        check_eq("rst_cnt", cycle_cnt, 0);
        check_eq("rst_ready", cfg_ready, 1);

        // Sawtooth at quarter-rate
        start_run(32'h4000_0000, 2'd1, 12'd4095, 12'd0);
        for (int k = 1; k <= 14; k++) begin
            tick;
            if (k >= 3) begin
                i = k - 3;
                check_eq($sformatf("saw_da%0d", i), da_data, saw4[i % 4]);
                check_eq($sformatf("saw_sync%0d", i), sync_pulse, (i > 0 && i % 4 == 0) ? 1 : 0);
                check_eq($sformatf("saw_cnt%0d", i), cycle_cnt, k / 4);
            end
        end
        check_eq("saw_ready", cfg_ready, 1);

        // Square with amplitude and offset
        start_run(32'h4000_0000, 2'd0, 12'd2048, 12'd1024);
        for (int k = 1; k <= 10; k++) begin
            tick;
            if (k >= 3) begin
                i = k - 3;
                check_eq($sformatf("sq_da%0d", i), da_data, (i % 4 < 2) ? 3071 : 1024);
            end
        end

        // Square saturating against a large offset
        start_run(32'h4000_0000, 2'd0, 12'd4095, 12'd4000);
        for (int k = 1; k <= 10; k++) begin
            tick;
            if (k >= 3) begin
                i = k - 3;
                check_eq($sformatf("sat_da%0d", i), da_data, (i % 4 < 2) ? 4095 : 4000);
            end
        end

        // Saw -> triangle switch at mid-period, applied at the wrap
        start_run(32'h1000_0000, 2'd1, 12'd4095, 12'd0);
        for (int k = 1; k <= 21; k++) begin
            tick;
            case (k)
                5:  check_eq("sw_ready_pre", cfg_ready, 1);
                6:  check_eq("sw_ready_pend", cfg_ready, 0);
                8:  check_eq("sw_saw_da", da_data, 1279);
                15: check_eq("sw_ready_hold", cfg_ready, 0);
                16: begin
                    check_eq("sw_ready_back", cfg_ready, 1);
                    check_eq("sw_cnt", cycle_cnt, 1);
                end
                18: begin
                    check_eq("sw_last_saw", da_data, 3839);
                    check_eq("sw_sync18", sync_pulse, 0);
                end
                19: begin
                    check_eq("sw_first_tri", da_data, 0);
                    check_eq("sw_sync19", sync_pulse, 1);
                end
                20: begin
                    check_eq("sw_tri1", da_data, 511);
                    check_eq("sw_sync20", sync_pulse, 0);
                end
                21: check_eq("sw_tri2", da_data, 1023);
                default: ;
            endcase
            if (k == 5) begin
                set_cfg(32'h1000_0000, 2'd2, 12'd4095, 12'd0);
                cfg_valid = 1'b1;
            end
            if (k == 6) cfg_valid = 1'b0;
        end

        // Zero frequency: pending set applies on the very next edge
        start_run(32'h0, 2'd1, 12'd4095, 12'd0);
        set_cfg(32'h8000_0000, 2'd1, 12'd4095, 12'd0);
        cfg_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick;
            if (k == 1) begin
                cfg_valid = 1'b0;
                check_eq("z_ready_pend", cfg_ready, 0);
            end
            if (k == 2) check_eq("z_ready_applied", cfg_ready, 1);
            if (k >= 3 && k <= 8)
                check_eq($sformatf("z_cnt%0d", k), cycle_cnt, (k - 2) / 2);
            if (k >= 5) begin
                check_eq($sformatf("z_da%0d", k), da_data, (k % 2 == 0) ? 2047 : 0);
                check_eq($sformatf("z_sync%0d", k), sync_pulse, (k == 7 || k == 9) ? 1 : 0);
            end
        end

        // Reset while pending discards the shadow set
        start_run(32'h4000_0000, 2'd1, 12'd4095, 12'd0);
        for (int k = 1; k <= 13; k++) begin
            tick;
            if (k == 5) begin
                set_cfg(32'h4000_0000, 2'd0, 12'd4095, 12'd1000);
                cfg_valid = 1'b1;
            end
            if (k == 6) begin
                check_eq("rp_ready_pend", cfg_ready, 0);
                check_eq("rp_cnt_pre", cycle_cnt, 1);
                cfg_valid = 1'b0;
                rst = 1'b1;
            end
            if (k == 7) begin
                check_eq("rp_da", da_data, 0);
                check_eq("rp_sync", sync_pulse, 0);
                check_eq("rp_cnt", cycle_cnt, 0);
                check_eq("rp_ready", cfg_ready, 1);
                rst = 1'b0;
            end
            if (k == 10) check_eq("rp_da_idle", da_data, 0);
            if (k >= 11) begin
                check_eq($sformatf("rp_da_def%0d", k), da_data, 4094);
                check_eq($sformatf("rp_cnt_def%0d", k), cycle_cnt, 0);
            end
        end

        // Enable drops while pending: set applies on the idle-entry edge
        start_run(32'h1000_0000, 2'd1, 12'd4095, 12'd0);
        for (int k = 1; k <= 7; k++) begin
            tick;
            if (k == 2) begin
                set_cfg(32'h1000_0000, 2'd1, 12'd4095, 12'd1000);
                cfg_valid = 1'b1;
            end
            if (k == 3) begin
                check_eq("ep_ready_pend", cfg_ready, 0);
                cfg_valid = 1'b0;
                enable = 1'b0;
            end
            if (k == 4) check_eq("ep_ready_idle", cfg_ready, 1);
            if (k == 7) check_eq("ep_da_offset", da_data, 1000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/da_wave_gen.md
DA_WAVE_GEN -- requirements
Module: da_wave_gen

Interface
REQ-001 Parameter PHASE_W, default 32: phase accumulator and frequency-word width.
REQ-002 Parameter DATA_W, default 12: DAC sample, amplitude and offset width.
REQ-003 da_clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 enable  input  1  1 = generate waveform (RUN); 0 = idle.
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  block can accept configuration.
REQ-008 cfg_freq_word  input  PHASE_W  phase increment per clock.
REQ-009 cfg_wave_sel  input  2  0 square, 1 sawtooth, 2 triangle, 3 DC.
REQ-010 cfg_amp  input  DATA_W  amplitude scale, full scale = 4095.
REQ-011 cfg_offset  input  DATA_W  unsigned offset added after scaling.
REQ-012 da_data  output  DATA_W  sample to DAC, registered.
REQ-013 sync_pulse  output  1  one-cycle pulse aligned with the first sample of each period.
REQ-014 cycle_cnt  output  16  count of completed periods.

Function
REQ-015 The configuration transfer SHALL occur on a clock where cfg_valid=1 and cfg_ready=1; the cfg_* fields are captured into shadow registers.
REQ-016 The FSM SHALL have states IDLE, RUN, PENDING: IDLE->RUN when enable=1; RUN->PENDING on a transfer; PENDING->RUN when the shadow set is applied; any state->IDLE when enable=0.
REQ-017 In IDLE, a transfer SHALL copy the shadow set into the active set on the next edge; cfg_ready=1.
REQ-018 In RUN, cfg_ready SHALL be 1; in PENDING, cfg_ready SHALL be 0.
REQ-019 In RUN/PENDING, phase SHALL update as phase <= (phase + freq_active) mod 2^PHASE_W every clock; the carry out of that add is the wrap event.
REQ-020 In PENDING, on the edge registering a wrap, the active wave/amp/offset/freq SHALL load from the shadow set; the wrapped sample is the first to use the new wave/amp/offset; the following accumulation uses the new freq; phase is not cleared.
REQ-021 If freq_active=0 while PENDING, the shadow set SHALL be applied on the next edge without waiting for a wrap.
REQ-022 In IDLE, phase SHALL be held at 0 and the raw stage forced to 0.
REQ-023 Raw stage (DATA_W bits, from phase MSBs): square = 4095 if phase[31]=0, else 0; sawtooth = phase[31:20]; triangle = phase[30:19] if phase[31]=0, else bitwise-inverted phase[30:19]; DC = 2048.
REQ-024 Scale stage: scaled = bits [23:12] of the 24-bit product raw*amp_active.
REQ-025 Offset stage: da_data = scaled + offset_active, computed 13 bits wide and saturated to 4095.
REQ-026 da_data SHALL lag the phase register by exactly 3 clocks (raw, scale, offset registers); wave/amp/offset travel with their sample through the pipeline.
REQ-027 sync_pulse SHALL be 1 for one clock, delayed so it is coincident with da_data of the sample registered at the wrap.
REQ-028 cycle_cnt SHALL increment on each wrap, wrap 65535->0, and hold in IDLE.
REQ-029 When enable falls while PENDING, the pending shadow set SHALL be applied on the IDLE-entry edge.

Reset
REQ-030 On rst=1: state IDLE, phase 0, all pipeline registers 0, da_data 0, sync_pulse 0, cycle_cnt 0, cfg_ready 1, freq_active 0, wave_active 0, amp_active 4095, offset_active 0, shadow set equal to the active set.
REQ-031 Reset SHALL take priority over enable and cfg_valid on the same edge, including mid-operation and in PENDING, where the pending set is discarded.

Verification
REQ-032 Reset; configure in IDLE with freq 0x4000_0000, saw, amp 4095, offset 0; enable -> da_data sequence 0,1023,2047,3071 repeating from the 3rd clock after the first RUN edge; sync_pulse every 4 clocks with the 0 sample; cycle_cnt +1 per 4 clocks.
REQ-033 Square, amp 2048, offset 1024, freq 0x4000_0000 -> da_data alternates 3071,3071,1024,1024.
REQ-034 Square, amp 4095, offset 4000 -> high samples saturate to 4095; low samples equal 4000.
REQ-035 In RUN at freq 0x1000_0000, transfer saw->triangle at a mid-period phase -> cfg_ready 0 until the wrap; the first triangle sample coincides with sync_pulse; cfg_ready returns to 1 on the next clock.
REQ-036 freq_active=0 in RUN, then a transfer with freq 0x8000_0000 -> applied on the next edge; wraps every 2 clocks thereafter.
REQ-037 Assert rst for 1 clock while PENDING -> all outputs take the REQ-030 values on the next clock, cfg_ready=1, and the pending set is lost.
